// File: rtl/raster_fifo_reader_if.sv
// Bus bundle for the raster FIFO reader: the FIFO read port plus the downstream stream.
// Stream rule: a word transfers on every rising edge where out_valid && out_ready; once
// raised, out_valid and out_dat hold until that transfer and out_valid never depends on out_ready.
interface raster_fifo_reader_if #(
    parameter int DAT_WID = 4
);
    logic               fifo_empty;
    logic               fifo_read_enable;
    logic [DAT_WID-1:0] fifo_read_dat;
    logic [DAT_WID-1:0] out_dat;
    logic               out_valid;
    logic               out_ready;

    modport master (
        input  fifo_empty,
        input  fifo_read_dat,
        input  out_ready,
        output fifo_read_enable,
        output out_dat,
        output out_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_read_dat,
        output out_ready,
        input  fifo_read_enable,
        input  out_dat,
        input  out_valid
    );
endinterface

// File: rtl/raster_fifo_reader.sv
// Drains burst_len words from the raster FIFO onto a valid/ready stream, hiding the
// FIFO's one-cycle read latency with a 2-entry output buffer.
module raster_fifo_reader #(
    parameter int DAT_WID = 4,
    parameter int CNT_WID = 16
) (
    input  logic                clk,
    input  logic                rst_L,
    input  logic                start,
    input  logic [CNT_WID-1:0]  burst_len,
    raster_fifo_reader_if.master bus,
    output logic                busy,
    output logic                done,
    output logic [CNT_WID-1:0]  words_left,
    output logic [1:0]          state_dbg
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WID-1:0] CNT_ONE = CNT_WID'(1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_WID-1:0] to_issue;
    logic [CNT_WID-1:0] words_left_q;
    logic               inflight;
    logic [1:0]         occ;
    logic [DAT_WID-1:0] buf0;
    logic [DAT_WID-1:0] buf1;

    logic               pop;
    logic               rd_en;
    logic               take_start;
    logic [2:0]         occ_proj;

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        rd_en      = 1'b0;
        take_start = 1'b0;
        // Occupancy the buffer will have next cycle, before any new read lands.
        occ_proj   = {1'b0, occ} + {2'b00, inflight};
        case (state)
            ST_IDLE: begin
                take_start = start;
                if (start) begin
                    state_nxt = (burst_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                pop      = (occ != 2'd0) && bus.out_ready;
                occ_proj = occ_proj - {2'b00, pop};
                rd_en    = !bus.fifo_empty && (to_issue != '0) && (occ_proj <= 3'd1);
                if (pop && (words_left_q == CNT_ONE)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            to_issue     <= '0;
            words_left_q <= '0;
            inflight     <= 1'b0;
            occ          <= 2'd0;
            buf0         <= '0;
            buf1         <= '0;
        end else if (take_start) begin
            to_issue     <= burst_len;
            words_left_q <= burst_len;
            inflight     <= 1'b0;
            occ          <= 2'd0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                to_issue <= to_issue - CNT_ONE;
            end
            if (pop && (words_left_q != '0)) begin
                words_left_q <= words_left_q - CNT_ONE;
            end
            // Head lives in buf0; a push into a buffer whose only word is leaving goes straight to the head.
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf0 <= bus.fifo_read_dat;
                    end else begin
                        buf1 <= bus.fifo_read_dat;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= bus.fifo_read_dat;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= bus.fifo_read_dat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.fifo_read_enable = rd_en;
    assign bus.out_valid        = (state == ST_RUN) && (occ != 2'd0);
    assign bus.out_dat          = buf0;
    assign busy                 = (state != ST_IDLE);
    assign done                 = (state == ST_DONE);
    assign words_left           = words_left_q;
    assign state_dbg            = state;
endmodule

// File: doc/raster_fifo_reader.md
# raster_fifo_reader

Read-side drain engine for the raster sample `ram_fifo`. On a `start` pulse it pulls exactly `burst_len` words from the FIFO's read port. It hides the FIFO's one-cycle read latency and presents the words on a valid/ready stream with full one-word-per-cycle throughput. It sits between the raster FIFO and the downstream consumer (serializer / bus bridge) and is the consumer-side counterpart of the FIFO writer.

## Interface
- `DAT_WID`, 4, data word width; must match the FIFO `DAT_WID`.
- `CNT_WID`, 16, width of the burst length and remaining-word counters.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_L`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `burst_len`  in  CNT_WID  number of words to transfer; sampled when `start` is honoured.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_read_enable`  out  1  FIFO read strobe.
- `fifo_read_dat`  in  DAT_WID  FIFO read data; valid the cycle after `fifo_read_enable`.
- `out_dat`  out  DAT_WID  stream data (buffer head).
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready from the consumer.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse at burst completion.
- `words_left`  out  CNT_WID  words not yet accepted downstream.

## Operation
- States:
  - IDLE -> RUN on `start` with `burst_len != 0`.
  - IDLE -> DONE on `start` with `burst_len == 0`.
  - RUN -> DONE on the handshake of the last word.
  - DONE -> IDLE unconditionally.
- On honouring `start`:
  - `to_issue` and `words_left` load `burst_len`.
  - Output buffer is empty; in-flight flag is cleared.
- Output buffer: 2-entry FIFO of registers. `out_dat`/`out_valid` reflect the head entry.
- Issue rule, RUN only: `fifo_read_enable = !fifo_empty && to_issue != 0 && (occ + inflight - pop) <= 1`.
  - `occ` is buffer occupancy (0..2).
  - `inflight` is the registered `fifo_read_enable` of the previous cycle.
  - `pop = out_valid && out_ready`.
  - `fifo_read_enable` is combinational from these terms; a `out_ready` -> `fifo_read_enable` path is permitted.
- Each issue decrements `to_issue`.
- When `inflight` is high, `fifo_read_dat` is pushed into the buffer at the end of that cycle.
- Each handshake (`pop`) decrements `words_left` and removes the head.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - Ordering is preserved, including the push into an empty buffer while the head is popped.
- The FIFO is never read while `fifo_empty` is high; underflow is impossible by construction.
- `start` in RUN/DONE is ignored; `burst_len` is not re-sampled.
- `out_valid` never asserts in IDLE. `out_dat` is don't-care when `out_valid` is low.
- Counters never wrap: `to_issue` and `words_left` stop at 0.

## Timing
- Reset (`rst_L` low, asynchronous, any state including mid-burst):
  - State = IDLE; buffer and in-flight flag are cleared.
  - `fifo_read_enable=0`, `out_valid=0`, `out_dat=0`, `busy=0`, `done=0`, `words_left=0`.
  - Any in-flight FIFO word is discarded.
- `start` in cycle 0 -> `busy=1` from cycle 1; earliest `fifo_read_enable` is cycle 1.
- `fifo_read_enable` in cycle k -> word visible on `out_dat` with `out_valid=1` in cycle k+2.
  - Start-to-first-valid latency: 3 cycles.
- Steady state with `out_ready=1` and the FIFO non-empty: one word per cycle.
- Backpressure (`out_ready=0`):
  - At most 2 words buffered plus 0 in flight.
  - Reads resume in the same cycle `out_ready` returns high.
- Last handshake in cycle n -> state DONE in cycle n+1 with `done=1`, `busy=1` -> IDLE in cycle n+2.
- `burst_len=0`: `start` in cycle 0 -> `done=1` in cycle 1, no FIFO reads.
- FIFO going empty mid-burst: issue stalls with no bubbles or duplicates; resumes the cycle `fifo_empty` falls.

## Test plan
- FIFO preloaded with 0x1..0x8, `burst_len=8`, `out_ready=1`:
  - `fifo_read_enable` high cycles 1-8.
  - `out_valid` high cycles 3-10 with data 0x1..0x8.
  - `done` pulse in cycle 11; `words_left` counts 8 -> 0.
- Same preload, `out_ready` toggled 1,0,0,1,…:
  - Data order is intact; no FIFO read while occ+inflight would exceed 2.
  - Exactly 8 reads total; buffer never overflows.
- FIFO holds 3 words, `burst_len=5`; 2 more words are written 10 cycles later:
  - Reads stall with `fifo_empty=1`, then resume.
  - All 5 words delivered in order; `done` after the 5th handshake.
- `burst_len=0`:
  - `done=1` in cycle 1, `busy` high only in cycle 1.
  - `fifo_read_enable` never asserted.
- Second `start` issued during RUN:
  - Ignored; `words_left` unaffected.
  - A `start` in IDLE after `done` begins a new burst.
- `rst_L` pulled low asynchronously mid-burst with a word in flight:
  - All outputs reach reset values immediately.
  - The next burst after release delivers only new FIFO data, with no stale word.
